// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-path state encoding, default oversample ratio,
// and the counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    VERIFY = 2'd2
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Smallest width able to hold values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input; the reset value
// is selectable so idle-high lines come out of reset inactive.
module uart_sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= {STAGES{RESET_VAL}};
    end else begin
      r_shift <= {r_shift[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_shift[STAGES-1];

endmodule

// File: rtl/uart_rx_start_detect.sv
// UART receive start-bit detector: synchronises rx_in, finds a falling edge on an
// oversample tick and confirms it by a 3-sample majority vote around mid-bit.
module uart_rx_start_detect
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic baud_tick,
  input  logic rx_in,
  output logic rx_sync,
  output logic strt_bit,
  output logic false_start,
  output logic busy
);

  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned CW  = clog2(OVERSAMPLE + 1);
  localparam logic [CW-1:0] K_LO  = CW'(MID - 1);
  localparam logic [CW-1:0] K_MID = CW'(MID);
  localparam logic [CW-1:0] K_HI  = CW'(MID + 1);

  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_k;
  logic [1:0]    r_votes, w_votes_next;
  logic          r_prev, r_strt, r_false, r_busy;
  logic          w_rx_sync, w_fall, w_maj_zero, w_strt_next, w_false_next;

  uart_sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx_in),
    .o_q   (w_rx_sync)
  );

  assign w_fall = baud_tick & r_prev & ~w_rx_sync;
  assign w_k    = r_cnt + CW'(1);

  // Only the first two vote samples are stored; the third is the live
  // synchronised line at the decision tick.
  assign w_maj_zero = (~r_votes[1] & ~r_votes[0]) |
                      (~r_votes[1] & ~w_rx_sync)  |
                      (~r_votes[0] & ~w_rx_sync);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_votes_next = r_votes;
    w_strt_next  = 1'b0;
    w_false_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = HUNT;
      end
      HUNT: begin
        if (!start) begin
          w_state_next = IDLE;
        end else if (w_fall) begin
          w_state_next = VERIFY;
          w_cnt_next   = '0;
          w_votes_next = '0;
        end
      end
      VERIFY: begin
        if (!start) begin
          w_state_next = IDLE;
        end else if (baud_tick) begin
          w_cnt_next = w_k;
          if (w_k == K_LO || w_k == K_MID) w_votes_next = {r_votes[0], w_rx_sync};
          if (w_k == K_HI) begin
            if (w_maj_zero) begin
              w_strt_next  = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_false_next = 1'b1;
              w_state_next = HUNT;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_votes <= '0;
      r_prev  <= 1'b1;
      r_strt  <= 1'b0;
      r_false <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_votes <= w_votes_next;
      r_strt  <= w_strt_next;
      r_false <= w_false_next;
      r_busy  <= (w_state_next == VERIFY);
      if (baud_tick) r_prev <= w_rx_sync;
    end
  end

  assign rx_sync     = w_rx_sync;
  assign strt_bit    = r_strt;
  assign false_start = r_false;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_start_detect.sv
// Bench for uart_rx_start_detect: directed scenarios plus a random soak, every
// cycle compared against a tick-sample-list reference model.
module tb_uart_rx_start_detect;

  localparam int OS  = 16;
  localparam int SS  = 2;
  localparam int MID = OS / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic baud_tick = 1'b0;
  logic rx_in = 1'b1;
  logic rx_sync, strt_bit, false_start, busy;

  uart_rx_start_detect #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .baud_tick   (baud_tick),
    .rx_in       (rx_in),
    .rx_sync     (rx_sync),
    .strt_bit    (strt_bit),
    .false_start (false_start),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnum = 0;
  int div = 4;
  int n_strt = 0, n_false = 0, n_busy = 0;
  int strt_cyc = -1, edge_cyc = 0;

  // Reference model: line delay queue, tick samples since the edge, mode flags.
  logic m_q[$];
  logic m_samp[$];
  logic m_prev = 1'b1;
  bit   m_hunt = 1'b0, m_ver = 1'b0;
  logic e_strt = 1'b0, e_false = 1'b0, e_busy = 1'b0, e_sync = 1'b1;

  function automatic void model_step();
    logic s_old;
    int z;
    e_strt  = 1'b0;
    e_false = 1'b0;
    if (reset) begin
      m_q.delete();
      repeat (SS) m_q.push_back(1'b1);
      m_prev = 1'b1;
      m_hunt = 1'b0;
      m_ver  = 1'b0;
      m_samp.delete();
    end else begin
      s_old = m_q[0];
      if (m_ver) begin
        if (!start) begin
          m_ver = 1'b0;
        end else if (baud_tick) begin
          m_samp.push_back(s_old);
          if (m_samp.size() == MID + 1) begin
            z = 0;
            for (int i = MID - 2; i <= MID; i++) if (m_samp[i] == 1'b0) z++;
            m_ver = 1'b0;
            if (z >= 2) e_strt = 1'b1;
            else begin
              e_false = 1'b1;
              m_hunt  = 1'b1;
            end
          end
        end
      end else if (m_hunt) begin
        if (!start) m_hunt = 1'b0;
        else if (baud_tick && m_prev && !s_old) begin
          m_hunt = 1'b0;
          m_ver  = 1'b1;
          m_samp.delete();
        end
      end else if (start) begin
        m_hunt = 1'b1;
      end
      if (baud_tick) m_prev = s_old;
      void'(m_q.pop_front());
      m_q.push_back(rx_in);
    end
    e_busy = m_ver;
    e_sync = m_q[0];
  endfunction

  task automatic check_outputs();
    total++;
    assert (rx_sync === e_sync) else begin
      bad++; $error("FAIL rx_sync cyc=%0d got=%b exp=%b", cnum, rx_sync, e_sync);
    end
    total++;
    assert (strt_bit === e_strt) else begin
      bad++; $error("FAIL strt_bit cyc=%0d got=%b exp=%b", cnum, strt_bit, e_strt);
    end
    total++;
    assert (false_start === e_false) else begin
      bad++; $error("FAIL false_start cyc=%0d got=%b exp=%b", cnum, false_start, e_false);
    end
    total++;
    assert (busy === e_busy) else begin
      bad++; $error("FAIL busy cyc=%0d got=%b exp=%b", cnum, busy, e_busy);
    end
    if (strt_bit === 1'b1) begin
      n_strt++;
      strt_cyc = cnum + 1;
    end
    if (false_start === 1'b1) n_false++;
    if (busy === 1'b1) n_busy++;
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_strt = 0; n_false = 0; n_busy = 0; strt_cyc = -1;
  endtask

  task automatic cyc(input logic rx, input logic tk);
    @(negedge clk);
    rx_in = rx;
    baud_tick = tk;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    cnum++;
  endtask

  // One oversample period; the tick lands on the last clk so rx_sync shows rx.
  task automatic seg(input logic rx);
    for (int i = 0; i < div; i++) cyc(rx, i == div - 1);
  endtask

  task automatic segs(input logic rx, input int n);
    repeat (n) seg(rx);
  endtask

  initial begin
    int hold;
    logic r;

    reset = 1'b1; start = 1'b0;
    repeat (3) cyc(1'b1, 1'b0);
    expect_bit("rst_rx_sync", rx_sync, 1'b1);
    expect_bit("rst_strt", strt_bit, 1'b0);
    expect_bit("rst_false", false_start, 1'b0);
    expect_bit("rst_busy", busy, 1'b0);
    reset = 1'b0;
    start = 1'b1;
    segs(1'b1, 4);

    // clean frame
    clear_counts();
    seg(1'b0);
    edge_cyc = cnum - 1;
    segs(1'b0, OS - 1);
    segs(1'b1, 10);
    expect_eq("clean_strt", n_strt, 1);
    expect_eq("clean_false", n_false, 0);
    expect_eq("clean_latency", strt_cyc - edge_cyc, (MID + 1) * div + 1);

    // glitch of three ticks, then a clean frame
    clear_counts();
    segs(1'b0, 3);
    segs(1'b1, 12);
    expect_eq("glitch_false", n_false, 1);
    expect_eq("glitch_strt", n_strt, 0);
    expect_bit("glitch_busy", busy, 1'b0);
    clear_counts();
    segs(1'b0, OS);
    segs(1'b1, 10);
    expect_eq("after_glitch_strt", n_strt, 1);

    // line high only at tick MID: two of three votes low
    clear_counts();
    segs(1'b0, MID);
    seg(1'b1);
    segs(1'b0, OS - MID - 1);
    segs(1'b1, 10);
    expect_eq("voteA_strt", n_strt, 1);
    expect_eq("voteA_false", n_false, 0);

    // line high at ticks MID and MID+1
    clear_counts();
    segs(1'b0, MID);
    segs(1'b1, 12);
    expect_eq("voteB_false", n_false, 1);
    expect_eq("voteB_strt", n_strt, 0);

    // start low with a toggling line
    start = 1'b0;
    clear_counts();
    for (int i = 0; i < 160; i++) cyc(1'($urandom()), (i % 4) == 3);
    segs(1'b1, 3);
    expect_eq("nostart_strt", n_strt, 0);
    expect_eq("nostart_false", n_false, 0);
    expect_eq("nostart_busy", n_busy, 0);
    start = 1'b1;
    segs(1'b1, 3);

    // start dropped on tick 5 of verify
    clear_counts();
    segs(1'b0, 5);
    repeat (div - 1) cyc(1'b0, 1'b0);
    start = 1'b0;
    cyc(1'b0, 1'b1);
    expect_bit("drop_busy", busy, 1'b0);
    segs(1'b0, 4);
    segs(1'b1, 4);
    start = 1'b1;
    segs(1'b1, 12);
    expect_eq("drop_strt", n_strt, 0);
    expect_eq("drop_false", n_false, 0);

    // reset on tick 6 of verify
    clear_counts();
    segs(1'b0, 6);
    repeat (div - 1) cyc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b1);
    expect_bit("midrst_strt", strt_bit, 1'b0);
    expect_bit("midrst_false", false_start, 1'b0);
    expect_bit("midrst_busy", busy, 1'b0);
    expect_bit("midrst_rx_sync", rx_sync, 1'b1);
    reset = 1'b0;
    segs(1'b1, 12);
    expect_eq("midrst_after_strt", n_strt, 0);
    expect_eq("midrst_after_false", n_false, 0);

    // break: five bit periods low
    clear_counts();
    segs(1'b0, 5 * OS);
    segs(1'b1, 10);
    expect_eq("break_strt", n_strt, 1);
    expect_eq("break_false", n_false, 0);

    // back-to-back frames, start withheld during random data bits
    clear_counts();
    for (int f = 0; f < 4; f++) begin
      start = 1'b1;
      segs(1'b0, OS);
      start = 1'b0;
      for (int b = 0; b < 8; b++) segs(1'($urandom()), OS);
      start = 1'b1;
      segs(1'b1, OS);
    end
    expect_eq("b2b_strt", n_strt, 4);
    expect_eq("b2b_false", n_false, 0);

    // random soak: random line holds, tick spacing, start and reset
    hold = 0;
    r = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (hold == 0) begin
        r = ~r;
        hold = int'($urandom_range(1, 90));
      end
      hold--;
      if ($urandom_range(0, 299) == 0) start = ~start;
      reset = ($urandom_range(0, 999) == 0);
      cyc(r, $urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    cyc(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
